// File: rtl/fi_mem_fairness.sv
// fi_mem_fairness: per-channel fairness and protocol monitor for
// request/grant/response memory channels. Counts grant stalls, outstanding
// transactions and response delay, drives "must act now" hints for the
// stimulus side, and latches sticky violation flags.
module fi_mem_fairness #(
    parameter int NCH             = 2,
    parameter int MAX_GNT_STALL   = 3,
    parameter int MAX_RSP_DELAY   = 4,
    parameter int MAX_OUTSTANDING = 1,
    parameter int ALLOW_ERRORS    = 0,
    parameter int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    gnt,
    input  logic [NCH-1:0]    rsp,
    input  logic [NCH-1:0]    error,
    output logic [NCH*OW-1:0] outstanding,
    output logic [NCH-1:0]    must_gnt,
    output logic [NCH-1:0]    must_rsp,
    output logic [NCH-1:0]    viol_gnt,
    output logic [NCH-1:0]    viol_rsp,
    output logic [NCH-1:0]    viol_proto,
    output logic              any_viol
);

    localparam logic [4:0]    GNT_LIM = 5'(MAX_GNT_STALL - 1);
    localparam logic [4:0]    RSP_LIM = 5'(MAX_RSP_DELAY - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic          ERR_OK  = (ALLOW_ERRORS != 0);

    logic [4:0]    stall [NCH];
    logic [OW-1:0] outs  [NCH];
    logic [4:0]    delay [NCH];

    logic [NCH-1:0] hs;
    logic [NCH-1:0] rsp_ok;
    logic [NCH-1:0] proto_err;

    // 5-bit counters stop at all-ones instead of wrapping back to zero
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'h1f) ? v : v + 5'd1;
    endfunction

    // Hints depend only on req and registered counters, never on gnt/rsp
    always_comb begin
        hs          = '0;
        rsp_ok      = '0;
        proto_err   = '0;
        must_gnt    = '0;
        must_rsp    = '0;
        outstanding = '0;
        for (int i = 0; i < NCH; i++) begin
            hs[i]       = req[i] && gnt[i];
            rsp_ok[i]   = rsp[i] && (outs[i] != '0);
            must_gnt[i] = req[i] && (stall[i] >= GNT_LIM);
            must_rsp[i] = (outs[i] != '0) && (delay[i] >= RSP_LIM);
            outstanding[i*OW +: OW] = outs[i];
            // orphan response, overflow, or an error that is not allowed here
            proto_err[i] = (rsp[i] && (outs[i] == '0))
                        || (hs[i] && (outs[i] == OUT_MAX) && !rsp[i])
                        || (error[i] && (!rsp[i] || !ERR_OK));
        end
    end

    // Per-channel counters and sticky flags; any_viol trails the flags by a cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                stall[i] <= '0;
                outs[i]  <= '0;
                delay[i] <= '0;
            end
            viol_gnt   <= '0;
            viol_rsp   <= '0;
            viol_proto <= '0;
            any_viol   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // a retracted request keeps its accumulated stall
                if (gnt[i])
                    stall[i] <= '0;
                else if (req[i])
                    stall[i] <= sat_inc5(stall[i]);

                // handshake and legal response in the same cycle cancel out
                case ({hs[i], rsp_ok[i]})
                    2'b10: if (outs[i] != OUT_MAX) outs[i] <= outs[i] + OW'(1);
                    2'b01: outs[i] <= outs[i] - OW'(1);
                    default: ;
                endcase

                // delay restarts for the next-oldest transaction after each response
                if (rsp[i] || (outs[i] == '0))
                    delay[i] <= '0;
                else
                    delay[i] <= sat_inc5(delay[i]);

                if (must_gnt[i] && !gnt[i]) viol_gnt[i]   <= 1'b1;
                if (must_rsp[i] && !rsp[i]) viol_rsp[i]   <= 1'b1;
                if (proto_err[i])           viol_proto[i] <= 1'b1;
            end
            any_viol <= |{viol_gnt, viol_rsp, viol_proto};
        end
    end

endmodule
